// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: func encodings,
// FSM states and the decoded operation classes.
package muldiv_pkg;

  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    MF   = 3'd1,
    MT   = 3'd2,
    MUL  = 3'd3,
    DIV  = 3'd4
  } op_class_e;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Pipeline-side bundle of the HI/LO unit: instruction issue, operands,
// flush, and the stall/status/result signals returned to EX.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             issue;
  logic [5:0]       func;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] mf_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output issue, func, rs_val, rt_val, flush,
    input  stall, busy, done, mf_data, hi, lo
  );

  modport slave (
    input  issue, func, rs_val, rt_val, flush,
    output stall, busy, done, mf_data, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit_decode.sv
// Combinational classification of the R-type func field into HI/LO op
// class, signedness and HI-vs-LO select.
module muldiv_decode
  import muldiv_pkg::*;
(
  input  logic [5:0] func,
  output op_class_e  op_class,
  output logic       is_signed,
  output logic       sel_hi
);

  // func field to op class
  always_comb begin
    op_class  = NONE;
    is_signed = 1'b0;
    sel_hi    = 1'b0;
    case (func)
      FUNC_MFHI:  begin op_class = MF;  sel_hi = 1'b1; end
      FUNC_MTHI:  begin op_class = MT;  sel_hi = 1'b1; end
      FUNC_MFLO:  op_class = MF;
      FUNC_MTLO:  op_class = MT;
      FUNC_MULT:  begin op_class = MUL; is_signed = 1'b1; end
      FUNC_MULTU: op_class = MUL;
      FUNC_DIV:   begin op_class = DIV; is_signed = 1'b1; end
      FUNC_DIVU:  op_class = DIV;
      default:    op_class = NONE;
    endcase
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with private HI/LO
// registers; one bit per cycle, signs stripped on entry and restored in FIX.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  hilo_muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_e           state_r, state_nxt;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] m_r, q_r, r_r, hi_r, lo_r;
  logic             div_op_r, neg_q_r, neg_r_r, done_r;

  op_class_e        dec_class_s, op_class_s;
  logic             dec_signed_s, dec_sel_hi_s;
  logic             hilo_op_s, busy_s, accept_s, start_s;
  logic             rs_neg_s, rt_neg_s;
  logic [WIDTH-1:0] rs_mag_s, rt_mag_s;
  logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0] quot_fix_s, rem_fix_s;

  muldiv_decode u_decode (
    .func      (bus.func),
    .op_class  (dec_class_s),
    .is_signed (dec_signed_s),
    .sel_hi    (dec_sel_hi_s)
  );

  // operation gating, operand magnitudes and one iteration of the datapath
  always_comb begin
    if (dec_class_s == DIV && !DIV_EN) begin
      op_class_s = NONE;
    end else begin
      op_class_s = dec_class_s;
    end
    hilo_op_s   = (op_class_s != NONE);
    busy_s      = (state_r != IDLE);
    accept_s    = bus.issue && hilo_op_s && !busy_s && !bus.flush;
    start_s     = accept_s && (op_class_s == MUL || op_class_s == DIV);
    rs_neg_s    = dec_signed_s && bus.rs_val[WIDTH-1];
    rt_neg_s    = dec_signed_s && bus.rt_val[WIDTH-1];
    rs_mag_s    = rs_neg_s ? -bus.rs_val : bus.rs_val;
    rt_mag_s    = rt_neg_s ? -bus.rt_val : bus.rt_val;
    mul_sum_s   = {1'b0, r_r} + (q_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {r_r, q_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, m_r};
    prod_s      = {r_r, q_r};
    prod_fix_s  = neg_q_r ? -prod_s : prod_s;
    quot_fix_s  = neg_q_r ? -q_r : q_r;
    rem_fix_s   = neg_r_r ? -r_r : r_r;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next state; flush overrides every transition
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    state_nxt = start_s ? RUN : IDLE;
      RUN:     state_nxt = (cnt_r == {CW{1'b0}}) ? FIX : RUN;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      state_nxt = state_nxt;
    end
  end

  // datapath, counter and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CW{1'b0}};
      m_r      <= {WIDTH{1'b0}};
      q_r      <= {WIDTH{1'b0}};
      r_r      <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      div_op_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && op_class_s == MT) begin
            if (dec_sel_hi_s) hi_r <= bus.rs_val;
            else              lo_r <= bus.rs_val;
          end
          if (start_s) begin
            m_r      <= rt_mag_s;
            q_r      <= rs_mag_s;
            r_r      <= {WIDTH{1'b0}};
            cnt_r    <= CNT_INIT;
            div_op_r <= (op_class_s == DIV);
            // a zero divisor leaves the all-ones quotient unsigned
            neg_q_r  <= (rs_neg_s ^ rt_neg_s) &&
                        !(op_class_s == DIV && bus.rt_val == {WIDTH{1'b0}});
            neg_r_r  <= rs_neg_s;
          end
        end
        RUN: begin
          cnt_r <= cnt_r - CW'(1);
          if (DIV_EN && div_op_r) begin
            if (!div_diff_s[WIDTH]) begin
              r_r <= div_diff_s[WIDTH-1:0];
              q_r <= {q_r[WIDTH-2:0], 1'b1};
            end else begin
              r_r <= div_shift_s[WIDTH-1:0];
              q_r <= {q_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_r <= mul_sum_s[WIDTH:1];
            q_r <= {mul_sum_s[0], q_r[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!bus.flush) begin
            done_r <= 1'b1;
            if (DIV_EN && div_op_r) begin
              hi_r <= rem_fix_s;
              lo_r <= quot_fix_s;
            end else begin
              hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
              lo_r <= prod_fix_s[WIDTH-1:0];
            end
          end
        end
        default: cnt_r <= {CW{1'b0}};
      endcase
    end
  end

  assign bus.stall   = bus.issue && hilo_op_s && busy_s;
  assign bus.busy    = busy_s;
  assign bus.done    = done_r;
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;
  assign bus.mf_data = (accept_s && op_class_s == MF && dec_sel_hi_s) ? hi_r : lo_r;

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised multi-cycle multiply/divide unit with private HI/LO registers. It sits in EX beside the main ALU and receives the R-type `func` field and both register operands from ALU control. It decodes the HI/LO instruction class itself, runs an iterative shift-add multiply or restoring divide, and asserts a stall to the pipeline while a HI/LO access collides with an operation still in flight.

## Interface
Parameters
- `WIDTH`, 32: operand and HI/LO width; must be at least 4.
- `DIV_EN`, 1: when 0, `div`/`divu` are ignored and no divider logic is built.

Ports
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `issue`, in, 1: an R-type instruction is present in EX this cycle.
- `func`, in, 6: R-type function field.
- `rs_val`, in, WIDTH: first operand (multiplicand or dividend); data source for `mthi`/`mtlo`.
- `rt_val`, in, WIDTH: second operand (multiplier or divisor).
- `flush`, in, 1: kill any in-flight operation.
- `stall`, out, 1: combinational; hold EX and all earlier stages.
- `busy`, out, 1: a multiply or divide is in flight.
- `done`, out, 1: one-cycle pulse in the cycle after HI/LO are written by a completed multiply or divide.
- `mf_data`, out, WIDTH: combinational result for `mfhi`/`mflo`; HI/LO written back through the WB mux.
- `hi`, out, WIDTH: current HI register.
- `lo`, out, WIDTH: current LO register.

## Operation
- Decoded func values:
  - `mfhi` 010000, `mthi` 010001, `mflo` 010010, `mtlo` 010011.
  - `mult` 011000, `multu` 011001, `div` 011010, `divu` 011011.
  - Any other value is a non-HI/LO op: no effect, `stall` stays 0.
- An op is accepted when `issue` is 1, `func` is a HI/LO op, `busy` is 0 and `flush` is 0.
- `stall` = `issue` and HI/LO op and `busy`. The op is not accepted while `stall` is high; the pipeline re-presents it.
- `mfhi`/`mflo` accepted: `mf_data` = `hi`/`lo` in the same cycle; no state change. When the op is not `mfhi`/`mflo`, `mf_data` = `lo`.
- `mthi`/`mtlo` accepted: `rs_val` is written to HI or LO at the edge.
- Multiply/divide accepted: the FSM goes IDLE→RUN, latching operand magnitudes (signed ops) or raw values (unsigned ops), the sign flags and an iteration counter set to WIDTH−1.
  - RUN does one bit per cycle and decrements the counter; at 0 it goes to FIX.
  - FIX applies signs, writes HI/LO, then goes to IDLE with `done` set for one cycle.
- Multiply result: the 2·WIDTH product, with HI holding the upper half and LO the lower half. For signed ops the product is negated if the operand signs differ.
- Divide result: LO = quotient, HI = remainder. For signed ops the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
- Divide by zero: HI = dividend, LO = all ones, for both signed and unsigned. The operation still takes full latency.
- Signed most-negative ÷ −1: LO = 1 followed by zeros, HI = 0. This falls out of the unsigned-magnitude datapath wrapping; no special case is needed.
- `flush`:
  - Forces IDLE at the next edge; HI/LO keep their pre-operation values and no `done` pulse is generated.
  - An op issued in the same cycle as `flush` is discarded.

## Timing
- Reset (asynchronous, `rst_n` = 0): FSM = IDLE, counter = 0, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0. With `issue` at 0, `stall` = 0 and `mf_data` = 0.
- Reset asserted mid-operation: immediate return to the reset state; partial results are lost.
- Multiply/divide latency: accepted at edge E0; `busy` is high from E0 through E(WIDTH+1); HI/LO are valid and `done` = 1 in the cycle after E(WIDTH+1). This is WIDTH+1 cycles of occupancy.
- A HI/LO op issued in the FIX cycle stalls. A HI/LO op issued in the `done` cycle is accepted and sees the new HI/LO.
- `mthi`/`mtlo` take effect at the accepting edge; an `mfhi`/`mflo` one cycle later reads the new value.

## Structure
- Package `muldiv_pkg` holds the func localparams, the FSM enum (IDLE, RUN, FIX) and an op-class enum (NONE, MF, MT, MUL, DIV).
- Sub-module `muldiv_decode`: combinational `func` → op class, signedness and HI/LO select.
- The top level contains the FSM, the counter, the shared shift/accumulate datapath and the HI/LO registers.

## Test plan
All scenarios use `WIDTH` = 32.
- `mult` −1 × 2 → after 33 cycles HI = FFFFFFFF, LO = FFFFFFFE; `multu` with the same operands → HI = 00000001, LO = FFFFFFFE.
- `div` −7 / 2 → LO = FFFFFFFD, HI = FFFFFFFF; `divu` 7 / 0 → HI = 00000007, LO = FFFFFFFF.
- `div` 80000000 / FFFFFFFF → LO = 80000000, HI = 00000000; `done` pulses exactly once.
- `mfhi` issued 5 cycles after a `mult` acceptance → `stall` stays high until the `done` cycle, then `mf_data` = the new HI with `stall` = 0.
- `flush` in the 10th RUN cycle of a `div` → `busy` is 0 the next cycle, HI/LO are unchanged, no `done`. A non-HI/LO func issued while busy → `stall` = 0.
- `rst_n` pulsed low mid-`mult` → `hi`, `lo`, `busy`, `done` all 0 immediately. Then `mthi` 00001234 followed by `mfhi` → `mf_data` = 00001234.
